standlight_ctrl: RTL and testbench
==================================

# standlight_ctrl

Control stage that sits directly upstream of the stand-light output mux. It conditions the raw push-button (2-flop synchroniser, debounce, press-edge detect and long-press detect) and runs the mode state machine that drives the mux select. It also generates the four PWM brightness waveforms that the mux chooses between, so that `o_sel` and `o_pwm` connect straight to the mux's `sel` and `i_x` inputs.

## Interface
- `DEBOUNCE_CYCLES`, default 100_000: number of consecutive cycles a synchronised level must differ from the debounced level before it is accepted. Must be ≥ 1.
- `LONG_PRESS_CYCLES`, default 100_000_000: number of debounced-high cycles after which the lamp is forced OFF. Must be ≥ 2.
- `PWM_PERIOD`, default 100: PWM counter period. Must be a multiple of 4 and ≥ 4.
- `i_clk`  input  1  system clock; the only clock in the block.
- `i_reset_n`  input  1  asynchronous, active-low reset.
- `i_btn`  input  1  raw button, asynchronous to `i_clk`, active high.
- `o_sel`  output  3  mode select to the mux: 0 = OFF, 1..4 = LV1..LV4.
- `o_pwm`  output  4  brightness waveforms: bit k has duty (k+1)/4, i.e. 25/50/75/100 %.
- `o_btn_pulse`  output  1  one-cycle pulse on each accepted press; used for debug.

## Operation
- Synchroniser: two flops on `i_btn`, giving `btn_s`. Both flops reset to 0.
- Debounce:
  - `deb` and `deb_cnt` both reset to 0.
  - When `btn_s == deb`, `deb_cnt` clears to 0.
  - Otherwise `deb_cnt` increments. When it reaches `DEBOUNCE_CYCLES-1`, `deb` takes `btn_s` and `deb_cnt` clears.
  - Any intervening match restarts the count, so a glitch shorter than `DEBOUNCE_CYCLES` cycles never changes `deb`.
- Edge detect:
  - `deb_d` is `deb` delayed by one cycle.
  - `o_btn_pulse` is a registered version of `deb & ~deb_d`. It is high for exactly one cycle per press.
  - Release generates no pulse.
- Long press:
  - `hold_cnt` clears while `deb == 0`. While `deb == 1` it increments and saturates at `LONG_PRESS_CYCLES`.
  - `long_hit` is a one-cycle strobe, issued on the cycle `hold_cnt` reaches `LONG_PRESS_CYCLES-1`.
  - Exactly one `long_hit` is issued per press.
- Mode FSM: states OFF(0), LV1(1), LV2(2), LV3(3), LV4(4).
  - On `o_btn_pulse`: OFF→LV1→LV2→LV3→LV4→OFF (wrap-around from LV4 to OFF).
  - On `long_hit`: the next state is OFF from any state.
  - If `long_hit` and `o_btn_pulse` are high in the same cycle, `long_hit` wins.
  - Otherwise the state holds.
  - `o_sel` is the state register directly and only takes values 0..4. Any illegal encoding recovers to OFF on the next clock.
- Consequence of the above: a long press first advances one level (on the press pulse) and then forces OFF (at `long_hit`). Releasing afterwards has no effect.
- PWM:
  - `pwm_cnt` counts 0..`PWM_PERIOD-1` and wraps to 0. It is free-running and independent of mode.
  - Next value of `o_pwm[k]` is (`pwm_cnt` < (k+1)·`PWM_PERIOD`/4). The output is registered.
  - `o_pwm[3]` is therefore constant 1 after the first cycle out of reset.
- Reset mid-operation: assertion of `i_reset_n` immediately clears all state, whatever the FSM, debounce or PWM position. A button held through reset release must still satisfy the full debounce before it registers a press.

## Timing
- Reset values: `o_sel` = 0, `o_pwm` = 4'b0000, `o_btn_pulse` = 0. All internal counters and flops are 0.
- Press latency:
  - A clean `i_btn` rise sampled at edge N gives `btn_s` = 1 after edge N+1.
  - `deb` = 1 after edge N+1+`DEBOUNCE_CYCLES`.
  - `o_btn_pulse` is high during the following cycle.
  - `o_sel` updates on the edge that ends the pulse cycle.
- Long press: `o_sel` = 0 on the edge after `deb` has been high for `LONG_PRESS_CYCLES` cycles.
- PWM: period is `PWM_PERIOD` cycles. Over any full period, bit k is high for exactly (k+1)·`PWM_PERIOD`/4 cycles. Output lags `pwm_cnt` by 1 cycle.
- Throughput: one mode step per debounced press. No press is lost if the release-to-press gap is ≥ `DEBOUNCE_CYCLES`+2 cycles.

## Test plan
All scenarios use bench parameters `DEBOUNCE_CYCLES`=4, `LONG_PRESS_CYCLES`=20, `PWM_PERIOD`=8.
- Reset: hold `i_reset_n`=0 for 5 cycles, then release → `o_sel`=0 and `o_btn_pulse`=0 throughout. `o_pwm`=0000 during reset; first post-reset cycle `o_pwm`=1111.
- Mode cycling: apply 5 clean presses, each high 10 cycles and low 10 cycles → `o_sel` steps 1,2,3,4,0. Exactly one `o_btn_pulse` per press. Each step occurs 2+4+2 cycles after the rise.
- Bounce rejection: toggle `i_btn` every 2 cycles for 20 cycles, then leave it low → no `o_btn_pulse` and `o_sel` unchanged. Repeat with the toggles followed by a steady high → exactly one step.
- Long press: from `o_sel`=2, hold `i_btn` high for 40 cycles → `o_sel`=3 after the press, then 0 after 20 debounced-high cycles. Release → `o_sel` stays 0.
- PWM duty: run 32 cycles → per 8-cycle window, `o_pwm[0..3]` high for 2, 4, 6 and 8 cycles respectively. The pattern is periodic and unaffected by presses.
- Reset mid-operation: at `o_sel`=3 with `i_btn` held high, assert `i_reset_n` for 3 cycles → `o_sel`=0 immediately. After release with `i_btn` still high → one press is registered after 2+4+2 cycles (`o_sel`=1).

Source files
------------

// File: rtl/standlight_ctrl.sv
// rtl/standlight_ctrl.sv - stand-light button conditioning, mode FSM and PWM generator
module standlight_ctrl #(
  parameter int DEBOUNCE_CYCLES   = 100_000,
  parameter int LONG_PRESS_CYCLES = 100_000_000,
  parameter int PWM_PERIOD        = 100
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_btn,
  output logic [2:0] o_sel,
  output logic [3:0] o_pwm,
  output logic       o_btn_pulse
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam int PW = $clog2(PWM_PERIOD);

  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_PRESS_CYCLES);
  localparam logic [HW-1:0] HOLD_HIT = HW'(LONG_PRESS_CYCLES - 1);
  localparam logic [PW-1:0] PWM_LAST = PW'(PWM_PERIOD - 1);

  typedef enum logic [2:0] {
    S_OFF = 3'd0,
    S_LV1 = 3'd1,
    S_LV2 = 3'd2,
    S_LV3 = 3'd3,
    S_LV4 = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            deb_q, deb_d;
  logic [DW-1:0]   deb_cnt_q, deb_cnt_d;
  logic            deb_dly_q, deb_dly_d;
  logic            pulse_q, pulse_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [PW-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic [3:0]      pwm_q, pwm_d;
  logic            long_hit;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_q      <= 1'b0;
      deb_cnt_q  <= '0;
      deb_dly_q  <= 1'b0;
      pulse_q    <= 1'b0;
      hold_cnt_q <= '0;
      pwm_cnt_q  <= '0;
      pwm_q      <= 4'b0000;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      deb_cnt_q  <= deb_cnt_d;
      deb_dly_q  <= deb_dly_d;
      pulse_q    <= pulse_d;
      hold_cnt_q <= hold_cnt_d;
      pwm_cnt_q  <= pwm_cnt_d;
      pwm_q      <= pwm_d;
    end
  end

  always_comb begin
    sync1_d   = i_btn;
    sync2_d   = sync1_q;
    deb_d     = deb_q;
    deb_cnt_d = '0;
    // Any cycle where the synchronised level agrees with deb restarts the count.
    if (sync2_q != deb_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        deb_d = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
    deb_dly_d = deb_q;
    pulse_d   = deb_q & ~deb_dly_q;

    hold_cnt_d = '0;
    if (deb_q) begin
      hold_cnt_d = (hold_cnt_q == HOLD_MAX) ? hold_cnt_q : hold_cnt_q + 1'b1;
    end
    long_hit = deb_q && (hold_cnt_q == HOLD_HIT);

    pwm_cnt_d = (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + 1'b1;
    pwm_d     = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      pwm_d[k] = ({1'b0, pwm_cnt_q} < (PW+1)'((k + 1) * PWM_PERIOD / 4));
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= S_OFF;
    end else begin
      state_q <= state_d;
    end
  end

  // Long press overrides a coincident press pulse.
  always_comb begin
    state_d = state_q;
    if (long_hit) begin
      state_d = S_OFF;
    end else if (pulse_q) begin
      case (state_q)
        S_OFF:   state_d = S_LV1;
        S_LV1:   state_d = S_LV2;
        S_LV2:   state_d = S_LV3;
        S_LV3:   state_d = S_LV4;
        S_LV4:   state_d = S_OFF;
        default: state_d = S_OFF;
      endcase
    end else begin
      case (state_q)
        S_OFF, S_LV1, S_LV2, S_LV3, S_LV4: state_d = state_q;
        default:                           state_d = S_OFF;
      endcase
    end
  end

  always_comb begin
    o_sel       = state_q;
    o_pwm       = pwm_q;
    o_btn_pulse = pulse_q;
  end

endmodule

// File: tb/tb_standlight_ctrl.sv
// tb/tb_standlight_ctrl.sv - directed self-checking bench for standlight_ctrl
module tb_standlight_ctrl;

  logic       clk;
  logic       rst_n;
  logic       btn;
  logic [2:0] o_sel;
  logic [3:0] o_pwm;
  logic       o_btn_pulse;

  int checks = 0;
  int passes = 0;
  int pulse_cnt = 0;

  standlight_ctrl #(
    .DEBOUNCE_CYCLES  (4),
    .LONG_PRESS_CYCLES(20),
    .PWM_PERIOD       (8)
  ) dut (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .i_btn      (btn),
    .o_sel      (o_sel),
    .o_pwm      (o_pwm),
    .o_btn_pulse(o_btn_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_btn_pulse) pulse_cnt++;
  end

  typedef struct {
    int bounce;
    int high;
    int low;
    int exp_sel;
    int exp_pulses;
    int exp_lat;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int high, input int low);
    btn = 1'b1;
    repeat (high) step();
    btn = 1'b0;
    repeat (low) step();
  endtask

  task automatic apply_row(input vec_t v, input int idx);
    int p0;
    int lat;
    logic [2:0] prev;
    p0 = pulse_cnt;
    lat = -1;
    prev = o_sel;
    for (int i = 0; i < v.bounce; i++) begin
      btn = ((i / 2) % 2 == 0);
      step();
    end
    for (int i = 0; i < v.high; i++) begin
      btn = 1'b1;
      step();
      if (lat < 0 && o_sel != prev) lat = i + 1;
    end
    btn = 1'b0;
    repeat (v.low) step();
    chk($sformatf("row%0d_sel", idx), o_sel, v.exp_sel);
    chk($sformatf("row%0d_pulses", idx), pulse_cnt - p0, v.exp_pulses);
    chk($sformatf("row%0d_latency", idx), lat, v.exp_lat);
  endtask

  initial begin
    int p0;
    int lat;
    int ones[4];

    vecs[0] = '{0,  10, 10, 1, 1, 8};
    vecs[1] = '{0,  10, 10, 2, 1, 8};
    vecs[2] = '{0,  10, 10, 3, 1, 8};
    vecs[3] = '{0,  10, 10, 4, 1, 8};
    vecs[4] = '{0,  10, 10, 0, 1, 8};
    vecs[5] = '{20, 0,  10, 0, 0, -1};
    vecs[6] = '{20, 10, 10, 1, 1, 8};
    vecs[7] = '{0,  10, 10, 2, 1, 8};

    rst_n = 1'b0;
    btn   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rst_sel", o_sel, 0);
      chk("rst_pulse", o_btn_pulse, 0);
      chk("rst_pwm", o_pwm, 0);
    end
    rst_n = 1'b1;
    step();
    chk("first_pwm", o_pwm, 4'b1111);
    chk("first_sel", o_sel, 0);
    repeat (4) step();

    for (int r = 0; r < 8; r++) apply_row(vecs[r], r);

    // Long press from LV2: one step on press, then forced OFF.
    p0 = pulse_cnt;
    btn = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (i == 7)  chk("long_pre", o_sel, 2);
      if (i == 8)  chk("long_step", o_sel, 3);
      if (i == 25) chk("long_before_hit", o_sel, 3);
      if (i == 26) chk("long_off", o_sel, 0);
      if (i == 40) chk("long_hold", o_sel, 0);
    end
    chk("long_pulses", pulse_cnt - p0, 1);
    p0 = pulse_cnt;
    btn = 1'b0;
    repeat (20) step();
    chk("long_release_sel", o_sel, 0);
    chk("long_release_pulses", pulse_cnt - p0, 0);

    // PWM duty over four windows with a press in flight.
    fork
      press(10, 10);
      begin
        for (int w = 0; w < 4; w++) begin
          for (int k = 0; k < 4; k++) ones[k] = 0;
          for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 4; k++) ones[k] += int'(o_pwm[k]);
          end
          for (int k = 0; k < 4; k++)
            chk($sformatf("pwm_w%0d_b%0d", w, k), ones[k], 2 * (k + 1));
        end
      end
    join
    chk("pwm_press_sel", o_sel, 1);

    // Reset mid-operation with the button held.
    press(10, 10);
    chk("mid_pre_lv2", o_sel, 2);
    btn = 1'b1;
    repeat (10) step();
    chk("mid_pre_lv3", o_sel, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_sel", o_sel, 0);
    chk("mid_rst_pwm", o_pwm, 0);
    chk("mid_rst_pulse", o_btn_pulse, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    p0 = pulse_cnt;
    lat = -1;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (lat < 0 && o_sel != 3'd0) lat = i;
    end
    chk("mid_post_lat", lat, 8);
    chk("mid_post_sel", o_sel, 1);
    chk("mid_post_pulses", pulse_cnt - p0, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
